// File: rtl/register_bank_arc_pkg.sv
// Shared widths, register index map and helpers for the ARC register bank.
package register_bank_arc_pkg;

   localparam int DATAWIDTH_BUS  = 32;
   localparam int DATAWIDTH_ADDR = 6;
   localparam int NUM_REGS       = 38;

   localparam logic [DATAWIDTH_BUS-1:0] DATA_ZERO = '0;

   localparam logic [DATAWIDTH_ADDR-1:0] REG_R0    = 6'd0;
   localparam logic [DATAWIDTH_ADDR-1:0] REG_R1    = 6'd1;
   localparam logic [DATAWIDTH_ADDR-1:0] REG_R31   = 6'd31;
   localparam logic [DATAWIDTH_ADDR-1:0] REG_PC    = 6'd32;
   localparam logic [DATAWIDTH_ADDR-1:0] REG_TEMP0 = 6'd33;
   localparam logic [DATAWIDTH_ADDR-1:0] REG_TEMP1 = 6'd34;
   localparam logic [DATAWIDTH_ADDR-1:0] REG_TEMP2 = 6'd35;
   localparam logic [DATAWIDTH_ADDR-1:0] REG_TEMP3 = 6'd36;
   localparam logic [DATAWIDTH_ADDR-1:0] REG_IR    = 6'd37;

   // Entry 0 is a constant and 38..63 are unimplemented, so neither can be written.
   function automatic logic is_writable(input logic [DATAWIDTH_ADDR-1:0] addr);
      return (addr >= REG_R1) && (addr <= REG_IR);
   endfunction

endpackage

// File: rtl/register_bank_cell.sv
// One data-bus-wide register with synchronous active-high reset and load enable.
module register_bank_cell
   import register_bank_arc_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     load_i,
   input  logic [DATAWIDTH_BUS-1:0] d_i,
   output logic [DATAWIDTH_BUS-1:0] q_o
);

   logic [DATAWIDTH_BUS-1:0] data_q;
   logic [DATAWIDTH_BUS-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (load_i) data_d = d_i;
   end

   // Reset wins over a load in the same cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) data_q <= DATA_ZERO;
      else       data_q <= data_d;
   end

   assign q_o = data_q;

endmodule

// File: rtl/register_bank_arc.sv
// ARC register bank: write decoder, 37 register cells, two combinational read muxes
// and an optional same-cycle write-to-read bypass.
module register_bank_arc
   import register_bank_arc_pkg::*;
#(
   parameter int BYPASS_EN = 0
) (
   input  logic                      SC_RegBANK_CLOCK_50,
   input  logic                      SC_RegBANK_RESET_InHigh,
   input  logic                      SC_RegBANK_Write_InHigh,
   input  logic [DATAWIDTH_ADDR-1:0] SC_RegBANK_addrC_InBUS,
   input  logic [DATAWIDTH_BUS-1:0]  SC_RegBANK_dataC_InBUS,
   input  logic [DATAWIDTH_ADDR-1:0] SC_RegBANK_addrA_InBUS,
   input  logic [DATAWIDTH_ADDR-1:0] SC_RegBANK_addrB_InBUS,
   output logic [DATAWIDTH_BUS-1:0]  SC_RegBANK_dataA_OutBUS,
   output logic [DATAWIDTH_BUS-1:0]  SC_RegBANK_dataB_OutBUS
);

   logic [NUM_REGS-1:0]                    load_en;
   logic [NUM_REGS-1:0][DATAWIDTH_BUS-1:0] entries;
   logic                                   wr_hit;
   logic [DATAWIDTH_BUS-1:0]               data_a;
   logic [DATAWIDTH_BUS-1:0]               data_b;

   always_comb begin
      load_en = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         load_en[i] = SC_RegBANK_Write_InHigh
                      && is_writable(SC_RegBANK_addrC_InBUS)
                      && (SC_RegBANK_addrC_InBUS == DATAWIDTH_ADDR'(i));
      end
   end

   // A write that will actually land at the next edge; only such writes may bypass.
   assign wr_hit = (|load_en) && !SC_RegBANK_RESET_InHigh;

   assign entries[0] = DATA_ZERO;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_cell
      register_bank_cell u_cell (
         .clk_i  (SC_RegBANK_CLOCK_50),
         .rst_i  (SC_RegBANK_RESET_InHigh),
         .load_i (load_en[g]),
         .d_i    (SC_RegBANK_dataC_InBUS),
         .q_o    (entries[g])
      );
   end

   always_comb begin
      data_a = DATA_ZERO;
      data_b = DATA_ZERO;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (SC_RegBANK_addrA_InBUS == DATAWIDTH_ADDR'(i)) data_a = entries[i];
         if (SC_RegBANK_addrB_InBUS == DATAWIDTH_ADDR'(i)) data_b = entries[i];
      end
      if ((BYPASS_EN != 0) && wr_hit) begin
         if (SC_RegBANK_addrA_InBUS == SC_RegBANK_addrC_InBUS) data_a = SC_RegBANK_dataC_InBUS;
         if (SC_RegBANK_addrB_InBUS == SC_RegBANK_addrC_InBUS) data_b = SC_RegBANK_dataC_InBUS;
      end
   end

   assign SC_RegBANK_dataA_OutBUS = data_a;
   assign SC_RegBANK_dataB_OutBUS = data_b;

endmodule

// File: tb/tb_register_bank_arc.sv
// Bench for register_bank_arc: drives a plain and a bypass build with the same vectors
// and checks their read ports against queued expectations at each falling edge.
module tb_register_bank_arc;
   import register_bank_arc_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we  = 1'b0;
   logic [5:0]  addr_c = '0;
   logic [31:0] data_c = '0;
   logic [5:0]  addr_a = '0;
   logic [5:0]  addr_b = '0;
   logic [31:0] data_a, data_b, byp_a, byp_b;

   logic        chk_valid = 1'b0;
   logic [95:0] exp_q[$];
   string       name_q[$];
   logic [31:0] mdl [NUM_REGS];
   int          passed = 0;
   int          total  = 0;

   always #5 clk = ~clk;

   register_bank_arc #(.BYPASS_EN(0)) u_dut (
      .SC_RegBANK_CLOCK_50     (clk),
      .SC_RegBANK_RESET_InHigh (rst),
      .SC_RegBANK_Write_InHigh (we),
      .SC_RegBANK_addrC_InBUS  (addr_c),
      .SC_RegBANK_dataC_InBUS  (data_c),
      .SC_RegBANK_addrA_InBUS  (addr_a),
      .SC_RegBANK_addrB_InBUS  (addr_b),
      .SC_RegBANK_dataA_OutBUS (data_a),
      .SC_RegBANK_dataB_OutBUS (data_b)
   );

   register_bank_arc #(.BYPASS_EN(1)) u_dut_byp (
      .SC_RegBANK_CLOCK_50     (clk),
      .SC_RegBANK_RESET_InHigh (rst),
      .SC_RegBANK_Write_InHigh (we),
      .SC_RegBANK_addrC_InBUS  (addr_c),
      .SC_RegBANK_dataC_InBUS  (data_c),
      .SC_RegBANK_addrA_InBUS  (addr_a),
      .SC_RegBANK_addrB_InBUS  (addr_b),
      .SC_RegBANK_dataA_OutBUS (byp_a),
      .SC_RegBANK_dataB_OutBUS (byp_b)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
   endtask

   // Monitor: the bench's own read request is the valid; outputs are sampled mid-cycle.
   always @(negedge clk) begin
      if (chk_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL queue_underrun: got 0 entries, expected 1");
         end else begin
            logic [95:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check({nm, "/A"},     data_a, e[95:64]);
            check({nm, "/B"},     data_b, e[63:32]);
            check({nm, "/A_byp"}, byp_a,  e[31:0]);
         end
      end
   end

   // Apply one cycle of inputs; the write (if any) lands at the following rising edge.
   task automatic step(input logic r, input logic w, input logic [5:0] ac, input logic [31:0] dc,
                       input logic [5:0] aa, input logic [5:0] ab, input logic chk,
                       input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] eab,
                       input string nm);
      @(posedge clk);
      #1;
      rst = r; we = w; addr_c = ac; data_c = dc; addr_a = aa; addr_b = ab;
      chk_valid = chk;
      if (chk) begin
         exp_q.push_back({ea, eb, eab});
         name_q.push_back(nm);
      end
      if (r) begin
         for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
      end else if (w && ac >= 6'd1 && ac <= 6'd37) begin
         mdl[ac] = dc;
      end
   endtask

   task automatic sweep(input string nm);
      for (int i = 1; i < NUM_REGS; i++) begin
         step(1'b0, 1'b0, 6'd0, 32'h0, 6'(i), 6'(NUM_REGS - i), 1'b1,
              mdl[i], mdl[NUM_REGS - i], mdl[i], nm);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no end of run, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
      // Reset then read; a write during reset is discarded and never bypassed
      step(1, 0, 6'd0, 32'h0, 6'd5, 6'd37, 0, 0, 0, 0, "");
      step(1, 0, 6'd0, 32'h0, 6'd5, 6'd37, 0, 0, 0, 0, "");
      step(1, 0, 6'd0, 32'h0, 6'd5, 6'd37, 1, 0, 0, 0, "reset_read");
      step(1, 1, 6'd5, 32'hFFFFFFFF, 6'd5, 6'd37, 1, 0, 0, 0, "write_in_reset_pre");
      step(0, 0, 6'd0, 32'h0, 6'd5, 6'd37, 1, 0, 0, 0, "write_in_reset_post");
      // Basic write/read
      step(0, 1, 6'd5, 32'hDEADBEEF, 6'd5, 6'd6, 1, 0, 0, 32'hDEADBEEF, "basic_pre");
      step(0, 0, 6'd0, 32'h0, 6'd5, 6'd6, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, "basic_post");
      // r0 and out-of-range writes
      step(0, 1, 6'd0,  32'h12345678, 6'd0,  6'd5, 1, 0, 32'hDEADBEEF, 0, "wr_r0");
      step(0, 1, 6'd38, 32'h12345678, 6'd38, 6'd6, 1, 0, 0, 0, "wr_38");
      step(0, 1, 6'd63, 32'h12345678, 6'd63, 6'd0, 1, 0, 0, 0, "wr_63");
      step(0, 0, 6'd0,  32'h0, 6'd0,  6'd38, 1, 0, 0, 0, "rd_0_38");
      step(0, 0, 6'd0,  32'h0, 6'd63, 6'd6,  1, 0, 0, 0, "rd_63_6");
      sweep("sweep_oor");
      // Same-cycle read/write on entry 10
      step(0, 1, 6'd10, 32'h1, 6'd10, 6'd10, 1, 0, 0, 32'h1, "bypass_first");
      step(0, 1, 6'd10, 32'h2, 6'd10, 6'd10, 1, 32'h1, 32'h1, 32'h2, "bypass_same_cycle");
      step(0, 0, 6'd0,  32'h0, 6'd10, 6'd10, 1, 32'h2, 32'h2, 32'h2, "bypass_after");
      // Write-enable gating on entry 20
      for (int k = 0; k < 3; k++)
         step(0, 0, 6'd20, 32'hAAAA5555, 6'd20, 6'd20, 1, 0, 0, 0, "we_low");
      step(0, 1, 6'd20, 32'hAAAA5555, 6'd20, 6'd20, 1, 0, 0, 32'hAAAA5555, "we_high");
      step(0, 0, 6'd0,  32'h0, 6'd20, 6'd20, 1, 32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555, "we_dual_read");
      // Reset mid-run
      for (int i = 1; i < NUM_REGS; i++)
         step(0, 1, 6'(i), 32'(i), 6'd0, 6'd0, 0, 0, 0, 0, "");
      step(1, 1, 6'd5, 32'h99, 6'd37, 6'd1, 1, 32'd37, 32'd1, 32'd37, "filled_at_reset");
      step(0, 1, REG_PC, 32'h7, REG_PC, 6'd5, 1, 0, 0, 32'h7, "pc_write");
      step(0, 0, 6'd0, 32'h0, REG_PC, REG_R31, 1, 32'h7, 0, 32'h7, "pc_read");
      sweep("sweep_after_reset");
      step(0, 0, 6'd0, 32'h0, 6'd0, 6'd0, 0, 0, 0, 0, "");
      @(negedge clk);
      @(negedge clk);
      total++;
      if (exp_q.size() == 0) passed++;
      else $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
